neuron_weight_mac_reader: RTL
=============================

// Module: neuron_weight_mac_reader
// PURPOSE
// - Read-side consumer of a per-neuron weight ROM (W_Mem_* family): drives ren/radd, takes wout one cycle later.
// - Pairs each weight with a streamed input activation and accumulates a signed fixed-point dot product.
// - Adds the neuron bias and emits one result per start.
// - Sits between the layer input stream and the activation stage, one instance per neuron.
// PARAMETERS
// - numWeight     30                     weights per neuron (ROM depth, >=2)
// - addressWidth  $clog2(numWeight)      ROM address width
// - dataWidth     16                     width of weight/activation/bias/result, two's complement
// - fracBits      12                     fractional bits of every dataWidth operand
// PORTS
// - clk      in   1                   clock, all state on rising edge
// - rst      in   1                   asynchronous active-high reset
// - start    in   1                   begin one neuron evaluation (sampled in IDLE only)
// - bias     in   dataWidth           neuron bias, sampled in BIAS state
// - x_valid  in   1                   input activation valid
// - x_in     in   dataWidth           input activation
// - x_ready  out  1                   high in RUN; beat accepted when x_valid & x_ready
// - ren      out  1                   ROM read enable, high only in cycle of an accepted beat
// - radd     out  addressWidth        ROM read address = beat index
// - wout     in   dataWidth           ROM data, valid 1 cycle after ren
// - y_out    out  dataWidth           neuron result, held until next result
// - y_valid  out  1                   1-cycle pulse with new y_out
// - busy     out  1                   high in any state except IDLE
// BEHAVIOUR
// - Reset: state IDLE; idx, acc, x_reg, beat-pipe flag = 0; x_ready, ren, radd, y_out, y_valid, busy = 0.
// - FSM: IDLE -> RUN on start; RUN -> DRAIN on accepting beat idx==numWeight-1.
//   DRAIN -> BIAS -> OUT -> IDLE, one cycle each.
// - RUN: accepted beat registers x_in into x_reg, asserts ren with radd=idx, idx++, sets pipe flag.
//   No beat: ren=0, flag cleared, idx/radd held.
// - Accumulate: cycle after a flagged beat, acc += x_reg * wout.
//   Full signed product 2*dataWidth bits; acc width 2*dataWidth+addressWidth, no overflow possible.
//   Happens in RUN or DRAIN.
// - BIAS: acc += sign-extended bias << fracBits.
// - OUT: r = acc >>> fracBits (floor, no rounding); y_out <= r narrowed per CONFIGURATION; y_valid=1.
// - Latency: x_valid held high -> y_valid asserted exactly numWeight+3 cycles after the start sampling edge.
// - start while busy: ignored. start with x_valid in same IDLE cycle: beat not accepted (x_ready=0).
// - idx returns to 0 on every entry to RUN; radd never exceeds numWeight-1, no wrap.
// - x_valid bubbles: stall only; result identical to gapless stream.
// - rst mid-operation: immediate return to reset state, partial sum discarded, no y_valid.
// CONFIGURATION
// - NEURON_SAT_EN defined: r above max signed dataWidth -> 0x7FFF; r below min -> 0x8000 (for dataWidth=16).
// - NEURON_SAT_EN undefined: y_out = r[dataWidth-1:0], plain truncation (wraps).
// TESTING
// - Reset, check ren, radd, x_ready, y_out, y_valid, busy all 0. Hold rst across clk edges: state stays IDLE.
// - numWeight=4, ROM all 0x1000, x=0x0800 gapless, bias=0 -> y_out=0x2000.
//   radd 0,1,2,3; y_valid at start+7.
// - Same config, x_valid pattern 1,0,0,1,1,0,1 -> y_out=0x2000.
//   ren only on accepted beats; busy held throughout.
// - numWeight=4, ROM 0xF000, x=0x1000, bias=0x0800 -> y_out=0xC800 (-3.5).
// - numWeight=4, ROM 0x7FFF, x=0x7FFF, bias=0:
//   with NEURON_SAT_EN y_out=0x7FFF; without y_out=0xFFC0.
// - Assert rst during RUN at idx=2, then start again -> radd restarts at 0, correct result.
//   start pulsed during RUN ignored, exactly one y_valid per accepted start.

Source files
------------

// File: rtl/neuron_weight_mac_reader_if.sv
// ---------------------------------------------------------------------------
// neuron_weight_mac_reader_if
// Purpose: bundles the layer-stream, weight-ROM and result signals of one
//          neuron MAC reader into a single port.
// Signals:
//   start    begin one neuron evaluation
//   bias     neuron bias, two's complement fixed point
//   x_valid  input activation valid
//   x_in     input activation
//   x_ready  reader can accept an activation beat
//   ren      weight ROM read enable
//   radd     weight ROM read address
//   wout     weight ROM data, valid one cycle after ren
//   y_out    neuron result
//   y_valid  one-cycle pulse with a new y_out
//   busy     evaluation in progress
// Modports: slave = the reader, master = the surrounding layer / ROM.
// ---------------------------------------------------------------------------
interface neuron_weight_mac_reader_if #(
    parameter int dataWidth    = 16,
    parameter int addressWidth = 5
);
    logic                    start;
    logic [dataWidth-1:0]    bias;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_in;
    logic                    x_ready;
    logic                    ren;
    logic [addressWidth-1:0] radd;
    logic [dataWidth-1:0]    wout;
    logic [dataWidth-1:0]    y_out;
    logic                    y_valid;
    logic                    busy;

    modport slave (
        input  start, bias, x_valid, x_in, wout,
        output x_ready, ren, radd, y_out, y_valid, busy
    );

    modport master (
        output start, bias, x_valid, x_in, wout,
        input  x_ready, ren, radd, y_out, y_valid, busy
    );
endinterface

// File: rtl/neuron_weight_mac_reader.sv
// ---------------------------------------------------------------------------
// neuron_weight_mac_reader
// Purpose: reads a per-neuron weight ROM in step with a streamed activation
//          input, accumulates the signed fixed-point dot product, adds the
//          bias and emits one result per start.
// Ports:
//   clk  in  clock, all state on rising edge
//   rst  in  asynchronous active-high reset
//   bus  neuron_weight_mac_reader_if.slave (start/bias/x_valid/x_in/wout in,
//        x_ready/ren/radd/y_out/y_valid/busy out)
// Build option: NEURON_SAT_EN defined -> result saturates to the signed
//   dataWidth range; undefined -> result is truncated (wraps).
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | accepting activation beats, one ROM read per beat
// DRAIN  | accumulate the product of the last beat
// BIAS   | add bias aligned to the accumulator's fixed point
// OUT    | narrow, publish y_out and pulse y_valid
// ---------------------------------------------------------------------------
module neuron_weight_mac_reader #(
    parameter int numWeight    = 30,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12,
    parameter int addressWidth = $clog2(numWeight)
) (
    input logic                       clk,
    input logic                       rst,
    neuron_weight_mac_reader_if.slave bus
);

    localparam int AccWidth = 2 * dataWidth + addressWidth;
    localparam int BiasPad  = AccWidth - dataWidth - fracBits;
    localparam logic [addressWidth-1:0] LastIdx = addressWidth'(numWeight - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_BIAS,
        S_OUT
    } state_t;

    state_t                       state_q;
    logic [addressWidth-1:0]      idx_q;
    logic signed [AccWidth-1:0]   acc_q;
    logic signed [dataWidth-1:0]  x_reg_q;
    logic                         beat_q;
    logic                         x_ready_q;
    logic                         busy_q;
    logic                         y_valid_q;
    logic [dataWidth-1:0]         y_out_q;

    logic                         beat;
    logic                         last_beat;
    logic signed [2*dataWidth-1:0] x_ext;
    logic signed [2*dataWidth-1:0] w_ext;
    logic signed [2*dataWidth-1:0] prod;
    logic signed [AccWidth-1:0]   prod_ext;
    logic signed [AccWidth-1:0]   bias_ext;
    logic signed [AccWidth-1:0]   acc_mac_d;
    logic [dataWidth-1:0]         y_d;

    // x_ready is only high in RUN, so this is exactly the accepted beat.
    assign beat      = x_ready_q & bus.x_valid;
    assign last_beat = beat & (idx_q == LastIdx);

    always_comb begin
        x_ext    = {{dataWidth{x_reg_q[dataWidth-1]}}, x_reg_q};
        w_ext    = {{dataWidth{bus.wout[dataWidth-1]}}, bus.wout};
        prod     = x_ext * w_ext;
        prod_ext = {{addressWidth{prod[2*dataWidth-1]}}, prod};
        bias_ext = {{BiasPad{bus.bias[dataWidth-1]}}, bus.bias, {fracBits{1'b0}}};
        // wout belongs to the beat flagged on the previous edge.
        acc_mac_d = beat_q ? (acc_q + prod_ext) : acc_q;
    end

`ifdef NEURON_SAT_EN
    localparam logic signed [AccWidth-1:0] SatMax =
        {{(AccWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatMin =
        {{(AccWidth-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
    logic signed [AccWidth-1:0] r;

    always_comb begin
        r = acc_q >>> fracBits;
        if (r > SatMax) begin
            y_d = {1'b0, {(dataWidth-1){1'b1}}};
        end else if (r < SatMin) begin
            y_d = {1'b1, {(dataWidth-1){1'b0}}};
        end else begin
            y_d = r[dataWidth-1:0];
        end
    end
`else
    // Floor shift then truncate is simply a bit slice of the accumulator.
    always_comb begin
        y_d = acc_q[fracBits +: dataWidth];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            x_reg_q   <= '0;
            beat_q    <= 1'b0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_out_q   <= '0;
        end else begin
            y_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_RUN;
                        idx_q     <= '0;
                        acc_q     <= '0;
                        beat_q    <= 1'b0;
                        x_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q  <= acc_mac_d;
                    beat_q <= beat;
                    if (beat) begin
                        x_reg_q <= bus.x_in;
                    end
                    if (last_beat) begin
                        // idx stays at the last address so radd never wraps.
                        state_q   <= S_DRAIN;
                        x_ready_q <= 1'b0;
                    end else if (beat) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    acc_q   <= acc_mac_d;
                    beat_q  <= 1'b0;
                    state_q <= S_BIAS;
                end
                S_BIAS: begin
                    acc_q   <= acc_q + bias_ext;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    y_out_q   <= y_d;
                    y_valid_q <= 1'b1;
                    busy_q    <= 1'b0;
                    idx_q     <= '0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    x_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    beat_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x_ready = x_ready_q;
    assign bus.ren     = beat;
    assign bus.radd    = idx_q;
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;

endmodule
